axis_flit_credit_tx: RTL and testbench

Credit-based flit transmitter: accepts an AXI-Stream packet, slices each beat into FLIT_WIDTH flits and drives one router input port (data/dest/is_tail/send) under credit flow control. It is the sending end of the router link protocol. It mirrors the router's credit_out and the downstream FLIT_BUFFER_DEPTH input buffer, for endpoints or test traffic generators that attach directly to a router port in the clk_noc domain. Single clock, no clock crossing.

---
 rtl/noc_pkg.sv | 18 +
 rtl/noc_credit_counter.sv | 46 ++++
 rtl/axis_flit_credit_tx.sv | 150 +++++++++++++++
 tb/tb_axis_flit_credit_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC link definitions: transmitter FSM states and derived-width helpers.
package noc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  function automatic int flit_width(input int tdata_width, input int sf);
    return tdata_width / sf;
  endfunction

  // A counter that must hold the value DEPTH itself needs one state beyond DEPTH-1.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter mirroring a downstream buffer: starts full, decrements per sent flit,
// increments per returned credit, saturates at DEPTH and flags an over-return (sticky).
module noc_credit_counter
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = credit_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          err_o
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (dec_i && !inc_i) begin
      count_d = count_q - CW'(1);
    end else if (inc_i && !dec_i) begin
      if (count_q == FULL) err_d = 1'b1;
      else                 count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= FULL;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o = count_q;
  assign err_o   = err_q;

endmodule

// File: rtl/axis_flit_credit_tx.sv
// AXI-Stream to credit-flow-controlled flit transmitter (one router input port).
// Optional AXIS_FLIT_TX_STATS_EN adds 32-bit flit/packet counters.
module axis_flit_credit_tx
  import noc_pkg::*;
#(
  parameter int TDATA_WIDTH          = 32,
  parameter int DEST_WIDTH           = 4,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int FLIT_WIDTH           = flit_width(TDATA_WIDTH, SERIALIZATION_FACTOR),
  parameter int FLIT_BUFFER_DEPTH    = 4,
  parameter int CREDIT_WIDTH         = credit_width(FLIT_BUFFER_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    axis_tvalid,
  output logic                    axis_tready,
  input  logic [TDATA_WIDTH-1:0]  axis_tdata,
  input  logic                    axis_tlast,
  input  logic [DEST_WIDTH-1:0]   axis_tdest,
  output logic [FLIT_WIDTH-1:0]   data_out,
  output logic [DEST_WIDTH-1:0]   dest_out,
  output logic                    is_tail_out,
  output logic                    send_out,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    credit_err
`ifdef AXIS_FLIT_TX_STATS_EN
  ,
  output logic [31:0]             stat_flits,
  output logic [31:0]             stat_packets
`endif
);

  localparam int SF    = SERIALIZATION_FACTOR;
  localparam int IDX_W = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SF - 1);

  tx_state_e state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [TDATA_WIDTH-1:0] beat_q;
  logic                   last_q;
  logic [DEST_WIDTH-1:0]  dest_q;
  logic                   load;
  logic                   issue;
  logic                   last_flit;
  logic [SF-1:0][FLIT_WIDTH-1:0] flits;

  logic                  send_q;
  logic                  tail_q;
  logic [FLIT_WIDTH-1:0] data_q;
  logic [DEST_WIDTH-1:0] dest_out_q;

  assign flits     = beat_q;
  assign issue     = (state_q == SEND) && (credit_count != '0);
  assign last_flit = (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load        = 1'b0;
    axis_tready = 1'b0;
    case (state_q)
      IDLE: begin
        axis_tready = 1'b1;
        if (axis_tvalid) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (issue) begin
          if (last_flit) begin
            // Accept the next beat in the same cycle the last flit leaves.
            axis_tready = 1'b1;
            idx_d       = '0;
            if (axis_tvalid) load = 1'b1;
            else             state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      beat_q     <= '0;
      last_q     <= 1'b0;
      dest_q     <= '0;
      send_q     <= 1'b0;
      tail_q     <= 1'b0;
      data_q     <= '0;
      dest_out_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      send_q  <= issue;
      if (load) begin
        beat_q <= axis_tdata;
        last_q <= axis_tlast;
        dest_q <= axis_tdest;
      end
      if (issue) begin
        data_q     <= flits[idx_q];
        dest_out_q <= dest_q;
        tail_q     <= last_q && last_flit;
      end
    end
  end

  noc_credit_counter #(
    .DEPTH (FLIT_BUFFER_DEPTH),
    .CW    (CREDIT_WIDTH)
  ) u_credit (
    .clk     (clk),
    .rst     (rst),
    .dec_i   (issue),
    .inc_i   (credit_in),
    .count_o (credit_count),
    .err_o   (credit_err)
  );

  assign send_out    = send_q;
  assign data_out    = data_q;
  assign dest_out    = dest_out_q;
  assign is_tail_out = tail_q;

`ifdef AXIS_FLIT_TX_STATS_EN
  logic [31:0] stat_flits_q, stat_packets_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_flits_q   <= '0;
      stat_packets_q <= '0;
    end else if (send_q) begin
      stat_flits_q <= stat_flits_q + 32'd1;
      if (tail_q) stat_packets_q <= stat_packets_q + 32'd1;
    end
  end

  assign stat_flits   = stat_flits_q;
  assign stat_packets = stat_packets_q;
`endif

endmodule

// File: tb/tb_axis_flit_credit_tx.sv
// Directed bench for axis_flit_credit_tx: SF=1 table run, SF=4 hand sequences, SF=2 traffic.
module tb_axis_flit_credit_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // SF=1 instance
  logic        a_tvalid = 0, a_tlast = 0, a_cin = 0;
  logic [31:0] a_tdata = '0;
  logic [3:0]  a_tdest = '0;
  logic        a_tready, a_send, a_tail, a_err;
  logic [31:0] a_data;
  logic [3:0]  a_dest;
  logic [2:0]  a_cnt;
  // SF=4 instance
  logic        b_tvalid = 0, b_tlast = 0, b_cin = 0;
  logic [31:0] b_tdata = '0;
  logic [3:0]  b_tdest = '0;
  logic        b_tready, b_send, b_tail, b_err;
  logic [7:0]  b_data;
  logic [3:0]  b_dest;
  logic [2:0]  b_cnt;
  // SF=2 instance
  logic        c_tvalid = 0, c_tlast = 0, c_cin = 0;
  logic [31:0] c_tdata = '0;
  logic [3:0]  c_tdest = '0;
  logic        c_tready, c_send, c_tail, c_err;
  logic [15:0] c_data;
  logic [3:0]  c_dest;
  logic [2:0]  c_cnt;
`ifdef AXIS_FLIT_TX_STATS_EN
  logic [31:0] a_sf, a_sp, b_sf, b_sp, c_sf, c_sp;
`endif

  axis_flit_credit_tx #(.SERIALIZATION_FACTOR(1)) dut_a (
    .clk(clk), .rst(rst), .axis_tvalid(a_tvalid), .axis_tready(a_tready),
    .axis_tdata(a_tdata), .axis_tlast(a_tlast), .axis_tdest(a_tdest),
    .data_out(a_data), .dest_out(a_dest), .is_tail_out(a_tail), .send_out(a_send),
    .credit_in(a_cin), .credit_count(a_cnt), .credit_err(a_err)
`ifdef AXIS_FLIT_TX_STATS_EN
    , .stat_flits(a_sf), .stat_packets(a_sp)
`endif
  );

  axis_flit_credit_tx #(.SERIALIZATION_FACTOR(4)) dut_b (
    .clk(clk), .rst(rst), .axis_tvalid(b_tvalid), .axis_tready(b_tready),
    .axis_tdata(b_tdata), .axis_tlast(b_tlast), .axis_tdest(b_tdest),
    .data_out(b_data), .dest_out(b_dest), .is_tail_out(b_tail), .send_out(b_send),
    .credit_in(b_cin), .credit_count(b_cnt), .credit_err(b_err)
`ifdef AXIS_FLIT_TX_STATS_EN
    , .stat_flits(b_sf), .stat_packets(b_sp)
`endif
  );

  axis_flit_credit_tx #(.SERIALIZATION_FACTOR(2)) dut_c (
    .clk(clk), .rst(rst), .axis_tvalid(c_tvalid), .axis_tready(c_tready),
    .axis_tdata(c_tdata), .axis_tlast(c_tlast), .axis_tdest(c_tdest),
    .data_out(c_data), .dest_out(c_dest), .is_tail_out(c_tail), .send_out(c_send),
    .credit_in(c_cin), .credit_count(c_cnt), .credit_err(c_err)
`ifdef AXIS_FLIT_TX_STATS_EN
    , .stat_flits(c_sf), .stat_packets(c_sp)
`endif
  );

  typedef struct {
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        cin;
    logic        e_send;
    logic [31:0] e_data;
    logic        e_tail;
    logic [2:0]  e_cnt;
    logic        e_tready;
    logic        e_err;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mv(logic tv, logic [31:0] d, logic tl, logic ci, logic es,
                              logic [31:0] ed, logic et, logic [2:0] ec, logic er, logic ee);
    vec_t v;
    v.tvalid = tv; v.tdata = d; v.tlast = tl; v.cin = ci;
    v.e_send = es; v.e_data = ed; v.e_tail = et; v.e_cnt = ec; v.e_tready = er; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int c_flits = 0;
  int c_pkts  = 0;
  always @(negedge clk) begin
    if (!rst && c_send) begin
      c_flits++;
      if (c_tail) c_pkts++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  bexp[4];
    logic [7:0]  sexp[4];
    logic        hs;

    tbl[0]  = mv(1'b1, 32'hA5A50000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 3'd4, 1'b1, 1'b0);
    tbl[1]  = mv(1'b1, 32'hA5A50001, 1'b0, 1'b0, 1'b1, 32'hA5A50000, 1'b0, 3'd3, 1'b1, 1'b0);
    tbl[2]  = mv(1'b1, 32'hA5A50002, 1'b0, 1'b0, 1'b1, 32'hA5A50001, 1'b0, 3'd2, 1'b1, 1'b0);
    tbl[3]  = mv(1'b1, 32'hA5A50003, 1'b0, 1'b0, 1'b1, 32'hA5A50002, 1'b0, 3'd1, 1'b1, 1'b0);
    tbl[4]  = mv(1'b1, 32'hA5A50004, 1'b0, 1'b0, 1'b1, 32'hA5A50003, 1'b0, 3'd0, 1'b0, 1'b0);
    tbl[5]  = mv(1'b1, 32'hA5A50005, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 1'b0);
    tbl[6]  = mv(1'b1, 32'hA5A50005, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 3'd1, 1'b1, 1'b0);
    tbl[7]  = mv(1'b1, 32'hA5A50005, 1'b1, 1'b0, 1'b1, 32'hA5A50004, 1'b0, 3'd0, 1'b0, 1'b0);
    tbl[8]  = mv(1'b0, 32'hA5A50005, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 3'd1, 1'b1, 1'b0);
    tbl[9]  = mv(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA5A50005, 1'b1, 3'd0, 1'b1, 1'b0);
    tbl[10] = mv(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 3'd0, 1'b1, 1'b0);
    tbl[11] = mv(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd1, 1'b1, 1'b0);
    tbl[12] = mv(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd2, 1'b1, 1'b0);
    tbl[13] = mv(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd3, 1'b1, 1'b0);
    tbl[14] = mv(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd4, 1'b1, 1'b0);
    tbl[15] = mv(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd4, 1'b1, 1'b1);
    tbl[16] = mv(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 3'd4, 1'b1, 1'b1);

    bexp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    sexp = '{8'h11, 8'h22, 8'h33, 8'h44};

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_send",   32'(a_send),   32'd0);
    chk("rst_data",   a_data,        32'd0);
    chk("rst_count",  32'(a_cnt),    32'd4);
    chk("rst_err",    32'(a_err),    32'd0);
    chk("rst_tready", 32'(a_tready), 32'd1);
    chk("rst_b_dest", 32'(b_dest),   32'd0);
    chk("rst_b_tail", 32'(b_tail),   32'd0);

    // SF=1: 6-flit packet against 4 credits, then credit over-return
    a_tdest = 4'h3;
    for (int i = 0; i < 17; i++) begin
      a_tvalid = tbl[i].tvalid;
      a_tdata  = tbl[i].tdata;
      a_tlast  = tbl[i].tlast;
      a_cin    = tbl[i].cin;
      @(posedge clk); #1;
      chk($sformatf("a%0d_send", i),   32'(a_send),   32'(tbl[i].e_send));
      chk($sformatf("a%0d_count", i),  32'(a_cnt),    32'(tbl[i].e_cnt));
      chk($sformatf("a%0d_tready", i), 32'(a_tready), 32'(tbl[i].e_tready));
      chk($sformatf("a%0d_err", i),    32'(a_err),    32'(tbl[i].e_err));
      if (tbl[i].e_send) begin
        chk($sformatf("a%0d_data", i), a_data,        tbl[i].e_data);
        chk($sformatf("a%0d_tail", i), 32'(a_tail),   32'(tbl[i].e_tail));
        chk($sformatf("a%0d_dest", i), 32'(a_dest),   32'h3);
      end
    end
    a_tvalid = 1'b0;
    a_cin    = 1'b0;

    // SF=4: one beat split LSB first
    b_tvalid = 1'b1; b_tdata = 32'hDDCCBBAA; b_tlast = 1'b1; b_tdest = 4'h9;
    @(posedge clk); #1;
    chk("b_lat_send", 32'(b_send), 32'd0);
    b_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b%0d_send", k), 32'(b_send), 32'd1);
      chk($sformatf("b%0d_data", k), 32'(b_data), 32'(bexp[k]));
      chk($sformatf("b%0d_dest", k), 32'(b_dest), 32'h9);
      chk($sformatf("b%0d_tail", k), 32'(b_tail), (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("b%0d_count", k), 32'(b_cnt), 32'(3 - k));
    end
    @(posedge clk); #1;
    chk("b_after_send",   32'(b_send),   32'd0);
    chk("b_after_tready", 32'(b_tready), 32'd1);

    // Return two credits, then stream with a credit every cycle
    b_cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    b_cin = 1'b0;
    b_tvalid = 1'b1; b_tdata = 32'h44332211; b_tlast = 1'b1; b_tdest = 4'h5;
    @(posedge clk); #1;
    chk("b_stream_cnt0", 32'(b_cnt), 32'd2);
    b_cin = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bs%0d_send", k),  32'(b_send), 32'd1);
      chk($sformatf("bs%0d_data", k),  32'(b_data), 32'(sexp[k % 4]));
      chk($sformatf("bs%0d_count", k), 32'(b_cnt),  32'd2);
    end
    b_tvalid = 1'b0;
    b_cin    = 1'b0;
    @(posedge clk); #1;
    chk("b_drain0_data", 32'(b_data), 32'h11);
    chk("b_drain0_cnt",  32'(b_cnt),  32'd1);
    @(posedge clk); #1;
    chk("b_drain1_data", 32'(b_data), 32'h22);
    chk("b_drain1_cnt",  32'(b_cnt),  32'd0);
    @(posedge clk); #1;
    chk("b_stall_send",   32'(b_send),   32'd0);
    chk("b_stall_tready", 32'(b_tready), 32'd0);
    chk("a_err_sticky",   32'(a_err),    32'd1);

    // Asynchronous reset in mid-packet
    #2 rst = 1'b1;
    #1;
    chk("rst_async_send", 32'(b_send), 32'd0);
    chk("rst_async_cnt",  32'(b_cnt),  32'd4);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_tready", 32'(b_tready), 32'd1);
    chk("rel_send",   32'(b_send),   32'd0);
    chk("rel_a_err",  32'(a_err),    32'd0);
    b_tvalid = 1'b1; b_tdata = 32'h87654321; b_tlast = 1'b1; b_tdest = 4'h2;
    @(posedge clk); #1;
    b_tvalid = 1'b0;
    @(posedge clk); #1;
    chk("new_pkt_send", 32'(b_send), 32'd1);
    chk("new_pkt_data", 32'(b_data), 32'h21);
    chk("new_pkt_cnt",  32'(b_cnt),  32'd3);

    // SF=2: 3 packets of 2 beats
    c_cin = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int bt = 0; bt < 2; bt++) begin
        c_tvalid = 1'b1;
        c_tdata  = 32'h1000_0000 + 32'(p * 2 + bt);
        c_tlast  = (bt == 1);
        c_tdest  = 4'(p);
        hs = 1'b0;
        for (int w = 0; w < 20; w++) begin
          @(negedge clk);
          hs = c_tready;
          @(posedge clk); #1;
          if (hs) break;
        end
        if (!hs) chk("c_handshake_timeout", 32'd0, 32'd1);
      end
    end
    c_tvalid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("c_flit_pulses", 32'(c_flits), 32'd12);
    chk("c_tail_pulses", 32'(c_pkts),  32'd3);
`ifdef AXIS_FLIT_TX_STATS_EN
    chk("stat_flits",   c_sf, 32'd12);
    chk("stat_packets", c_sp, 32'd3);
    chk("stat_flits_a", a_sf, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
